i2c_slave_fsm: RTL and testbench

I2C target (slave) controller: the responder end of the bus driven by the I2C master FSM. It samples the open-drain SCL/SDA lines in the system clock domain and detects START/STOP. It matches the 7-bit address, ACKs, receives write bytes and transmits read bytes. It presents bytes to local logic through a simple valid/request interface. It is used in the same testbenches as the master and as the on-chip register-port front end.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sampler.sv | 63 ++++++
 rtl/i2c_slave_fsm.sv | 263 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_fsm.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encodings, default widths and ACK/NACK bus levels.
// Used by the target (slave) controller and by the bus sampler.
package i2c_pkg;

   localparam int I2C_ADDR_LEN = 7;
   localparam int I2C_DATA_LEN = 8;

   // ACK is the line pulled low, NACK is the line left released
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // Target controller states (4-bit, same width as the master's states)
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ACK_ADDR  = 4'd2,
      ST_RX_DATA   = 4'd3,
      ST_ACK_RX    = 4'd4,
      ST_TX_DATA   = 4'd5,
      ST_ACK_TX    = 4'd6,
      ST_WAIT_STOP = 4'd7
   } i2c_slave_state_t;

endpackage

// File: rtl/i2c_bus_sampler.sv
// I2C bus sampler: synchronizes SCL/SDA into the clk domain and produces
// registered one-cycle pulses for SCL edges and START/STOP conditions.
// sda_sync is the SDA level aligned with the pulses, so it can be used
// directly as the data bit on scl_rise.
module i2c_bus_sampler #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_sync,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_r;
   logic [SYNC_STAGES-1:0] sda_sync_r;
   logic                   scl_prev_r;
   logic                   sda_prev_r;
   logic                   scl_rise_r;
   logic                   scl_fall_r;
   logic                   start_r;
   logic                   stop_r;
   logic                   scl_cur_s;
   logic                   sda_cur_s;

   assign scl_cur_s = scl_sync_r[SYNC_STAGES-1];
   assign sda_cur_s = sda_sync_r[SYNC_STAGES-1];

   // Synchronizer chains, previous-level registers and registered edge/condition pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_r <= {SYNC_STAGES{1'b1}};
         sda_sync_r <= {SYNC_STAGES{1'b1}};
         scl_prev_r <= 1'b1;
         sda_prev_r <= 1'b1;
         scl_rise_r <= 1'b0;
         scl_fall_r <= 1'b0;
         start_r    <= 1'b0;
         stop_r     <= 1'b0;
      end else begin
         scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
         scl_prev_r <= scl_cur_s;
         sda_prev_r <= sda_cur_s;
         scl_rise_r <= scl_cur_s & ~scl_prev_r;
         scl_fall_r <= ~scl_cur_s & scl_prev_r;
         // SDA moving while SCL is stably high marks START (fall) or STOP (rise)
         start_r    <= sda_prev_r & ~sda_cur_s & scl_cur_s & scl_prev_r;
         stop_r     <= ~sda_prev_r & sda_cur_s & scl_cur_s & scl_prev_r;
      end
   end

   assign sda_sync  = sda_prev_r;
   assign scl_rise  = scl_rise_r;
   assign scl_fall  = scl_fall_r;
   assign start_det = start_r;
   assign stop_det  = stop_r;

endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C target (slave) controller: detects START/STOP, matches the 7-bit
// address, ACKs, receives write bytes and transmits read bytes.
// Optional build macro I2C_SLAVE_STRETCH_EN: rx_valid is held until rx_ready
// and SCL is stretched low after the data ACK while the byte is unconsumed.
// Without it SCL is never driven and rx_ready is ignored.
module i2c_slave_fsm
   import i2c_pkg::*;
#(
   parameter int                  ADDR_LEN    = I2C_ADDR_LEN,
   parameter int                  DATA_LEN    = I2C_DATA_LEN,
   parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'h50,
   parameter int                  SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   inout  wire                 scl,
   inout  wire                 sda,
   input  logic [DATA_LEN-1:0] tx_data,
   input  logic                rx_ready,
   output logic [DATA_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic                tx_req,
   output logic                rw,
   output logic                busy,
   output logic                stop_det,
   output logic                nack_rcvd,
   output logic [3:0]          state_slave
);

   localparam int               CNT_W    = $clog2(DATA_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LEN - 1);
   localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(DATA_LEN);

   logic sda_sync_s;
   logic scl_rise_s;
   logic scl_fall_s;
   logic start_s;
   logic stop_s;

   i2c_slave_state_t    state_r;
   logic [CNT_W-1:0]    bit_cnt_r;
   logic [DATA_LEN-1:0] shift_r;
   logic                ack_phase_r;   // ACK states: first falling edge already seen / ACK received
   logic                sda_oe_r;
   logic [DATA_LEN-1:0] rx_data_r;
   logic                rx_valid_r;
   logic                tx_req_r;
   logic                rw_r;
   logic                busy_r;
   logic                stop_det_r;
   logic                nack_r;
`ifdef I2C_SLAVE_STRETCH_EN
   logic                scl_oe_r;
`endif

   i2c_bus_sampler #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sampler (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl),
      .sda_in    (sda),
      .sda_sync  (sda_sync_s),
      .scl_rise  (scl_rise_s),
      .scl_fall  (scl_fall_s),
      .start_det (start_s),
      .stop_det  (stop_s)
   );

   // Protocol FSM: state, bit counter, shift register, line drives and output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= '0;
         shift_r     <= '0;
         ack_phase_r <= 1'b0;
         sda_oe_r    <= 1'b0;
         rx_data_r   <= '0;
         rx_valid_r  <= 1'b0;
         tx_req_r    <= 1'b0;
         rw_r        <= 1'b0;
         busy_r      <= 1'b0;
         stop_det_r  <= 1'b0;
         nack_r      <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
         scl_oe_r    <= 1'b0;
`endif
      end else begin
         tx_req_r   <= 1'b0;
         stop_det_r <= 1'b0;
         nack_r     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
         // a consumed byte clears rx_valid and ends any stretch on the next cycle
         if (rx_ready) begin
            rx_valid_r <= 1'b0;
            scl_oe_r   <= 1'b0;
         end
`else
         rx_valid_r <= 1'b0;
`endif
         if (stop_s) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            ack_phase_r <= 1'b0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            stop_det_r  <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_r    <= 1'b0;
`endif
         end else if (start_s) begin
            // START from any state, including a repeated START mid-transfer
            state_r     <= ST_ADDR;
            bit_cnt_r   <= '0;
            ack_phase_r <= 1'b0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_r    <= 1'b0;
`endif
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_ADDR: begin
                  if (scl_rise_s) begin
                     shift_r <= {shift_r[DATA_LEN-2:0], sda_sync_s};
                     if (bit_cnt_r == LAST_BIT) begin
                        // shift_r holds the 7 address bits; the incoming bit is R/W
                        bit_cnt_r <= '0;
                        if (shift_r[ADDR_LEN-1:0] == SLAVE_ADDR) begin
                           rw_r        <= sda_sync_s;
                           busy_r      <= 1'b1;
                           ack_phase_r <= 1'b0;
                           state_r     <= ST_ACK_ADDR;
                        end else begin
                           state_r <= ST_WAIT_STOP;
                        end
                     end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                     end
                  end
               end
               ST_ACK_ADDR: begin
                  if (scl_fall_s) begin
                     if (!ack_phase_r) begin
                        sda_oe_r    <= 1'b1;
                        ack_phase_r <= 1'b1;
                     end else begin
                        ack_phase_r <= 1'b0;
                        if (rw_r) begin
                           shift_r   <= tx_data;
                           tx_req_r  <= 1'b1;
                           sda_oe_r  <= ~tx_data[DATA_LEN-1];
                           bit_cnt_r <= CNT_W'(1);
                           state_r   <= ST_TX_DATA;
                        end else begin
                           sda_oe_r  <= 1'b0;
                           bit_cnt_r <= '0;
                           state_r   <= ST_RX_DATA;
                        end
                     end
                  end
               end
               ST_RX_DATA: begin
                  if (scl_rise_s) begin
                     shift_r <= {shift_r[DATA_LEN-2:0], sda_sync_s};
                     if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_r   <= '0;
                        ack_phase_r <= 1'b0;
                        state_r     <= ST_ACK_RX;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                     end
                  end
               end
               ST_ACK_RX: begin
                  if (scl_fall_s) begin
                     if (!ack_phase_r) begin
                        rx_data_r   <= shift_r;
                        rx_valid_r  <= 1'b1;
                        sda_oe_r    <= 1'b1;
                        ack_phase_r <= 1'b1;
                     end else begin
                        sda_oe_r    <= 1'b0;
                        ack_phase_r <= 1'b0;
                        state_r     <= ST_RX_DATA;
`ifdef I2C_SLAVE_STRETCH_EN
                        // hold SCL low until local logic takes the byte
                        if (rx_valid_r && !rx_ready) begin
                           scl_oe_r <= 1'b1;
                        end
`endif
                     end
                  end
               end
               ST_TX_DATA: begin
                  if (scl_fall_s) begin
                     if (bit_cnt_r == ALL_BITS) begin
                        sda_oe_r    <= 1'b0;
                        bit_cnt_r   <= '0;
                        ack_phase_r <= 1'b0;
                        state_r     <= ST_ACK_TX;
                     end else begin
                        // shift_r[MSB] is the bit on the bus; present the next one
                        sda_oe_r  <= ~shift_r[DATA_LEN-2];
                        shift_r   <= {shift_r[DATA_LEN-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                     end
                  end
               end
               ST_ACK_TX: begin
                  if (scl_rise_s) begin
                     if (sda_sync_s == I2C_ACK) begin
                        ack_phase_r <= 1'b1;
                     end else begin
                        nack_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_WAIT_STOP;
                     end
                  end else if (scl_fall_s && ack_phase_r) begin
                     shift_r     <= tx_data;
                     tx_req_r    <= 1'b1;
                     sda_oe_r    <= ~tx_data[DATA_LEN-1];
                     bit_cnt_r   <= CNT_W'(1);
                     ack_phase_r <= 1'b0;
                     state_r     <= ST_TX_DATA;
                  end
               end
               ST_WAIT_STOP: begin
                  sda_oe_r <= 1'b0;
               end
               default: begin
                  state_r  <= ST_IDLE;
                  sda_oe_r <= 1'b0;
                  busy_r   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda = sda_oe_r ? 1'b0 : 1'bz;

`ifdef I2C_SLAVE_STRETCH_EN
   assign scl = scl_oe_r ? 1'b0 : 1'bz;
`else
   assign scl = 1'bz;
   logic unused_rx_ready_s;
   assign unused_rx_ready_s = rx_ready;
`endif

   assign rx_data     = rx_data_r;
   assign rx_valid    = rx_valid_r;
   assign tx_req      = tx_req_r;
   assign rw          = rw_r;
   assign busy        = busy_r;
   assign stop_det    = stop_det_r;
   assign nack_rcvd   = nack_r;
   assign state_slave = state_r;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Self-checking bench for i2c_slave_fsm: a bit-level bus master drives
// transactions with random payloads; expectations come from transaction-level
// rules (address match, bytes written/read, pulse counts).
module tb_i2c_slave_fsm;
   import i2c_pkg::*;

   localparam int         Q   = 6;       // quarter of an SCL bit period in clk cycles
   localparam logic [6:0] OWN = 7'h50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, rw, busy, stop_det, nack_rcvd;
   logic [3:0] state_slave;
   logic       m_scl_low = 1'b0;
   logic       m_sda_low = 1'b0;
   wire        scl_w;
   wire        sda_w;

   pullup (scl_w);
   pullup (sda_w);
   assign scl_w = m_scl_low ? 1'b0 : 1'bz;
   assign sda_w = m_sda_low ? 1'b0 : 1'bz;

   i2c_slave_fsm #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .scl(scl_w), .sda(sda_w),
      .tx_data(tx_data), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .tx_req(tx_req), .rw(rw), .busy(busy),
      .stop_det(stop_det), .nack_rcvd(nack_rcvd), .state_slave(state_slave)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   int         n_rxv = 0, n_txreq = 0, n_nack = 0, n_stop = 0, n_sda_slave = 0, n_scl_slave = 0;
   logic       rxv_q = 1'b0;
   logic [7:0] rx_seen[$];

   // Monitor: counts DUT pulses, slave-driven line lows and captures received bytes
   always @(negedge clk) begin
      rxv_q <= rx_valid;
      if (rx_valid === 1'b1) n_rxv <= n_rxv + 1;
      if (rx_valid === 1'b1 && rxv_q === 1'b0) rx_seen.push_back(rx_data);
      if (tx_req === 1'b1) n_txreq <= n_txreq + 1;
      if (nack_rcvd === 1'b1) n_nack <= n_nack + 1;
      if (stop_det === 1'b1) n_stop <= n_stop + 1;
      if (sda_w === 1'b0 && !m_sda_low) n_sda_slave <= n_sda_slave + 1;
      if (scl_w === 1'b0 && !m_scl_low) n_scl_slave <= n_scl_slave + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one SCL period; returns SDA sampled mid-high; waits (bounded) for stretched SCL
   task automatic m_bit(input logic b, output logic rd);
      m_sda_low = ~b;
      tick(Q);
      m_scl_low = 1'b0;
      for (int k = 0; k < 400 && scl_w !== 1'b1; k++) tick(1);
      check("scl_high", scl_w, 1'b1);
      tick(Q);
      rd = sda_w;
      tick(Q);
      m_scl_low = 1'b1;
      tick(Q);
   endtask

   task automatic m_byte(input logic [7:0] b, output logic [7:0] rd);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         m_bit(b[i], r);
         rd[i] = r;
      end
   endtask

   task automatic m_start();
      if (m_scl_low) begin
         m_sda_low = 1'b0;
         tick(Q);
         m_scl_low = 1'b0;
         tick(2 * Q);
      end
      m_sda_low = 1'b1;
      tick(2 * Q);
      m_scl_low = 1'b1;
      tick(Q);
   endtask

   task automatic m_stop();
      m_sda_low = 1'b1;
      tick(Q);
      m_scl_low = 1'b0;
      tick(2 * Q);
      m_sda_low = 1'b0;
      tick(2 * Q);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rd, d;
      logic [6:0] a;
      logic [7:0] exp_last;
      logic [7:0] exp_q[$];
      logic [7:0] txq[$];
      int         nb, b_rxv, b_tx, b_nack, b_stop, b_sda;

      exp_last = 8'h00;

      // reset state
      tick(3);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_flags", {rx_valid, tx_req, rw, busy, stop_det, nack_rcvd}, 6'b0);
      check("rst_state", state_slave, ST_IDLE);
      check("rst_lines", {scl_w, sda_w}, 2'b11);
      rst_n = 1'b1;
      tick(5);

      // write 0xA0, byte 0xA5, STOP
      b_rxv = n_rxv; b_stop = n_stop;
      m_start();
      m_byte(8'hA0, rd);
      m_bit(1'b1, ack);
      check("w_addr_ack", ack, I2C_ACK);
      check("w_busy", busy, 1'b1);
      check("w_rw", rw, 1'b0);
      check("w_state_rx", state_slave, ST_RX_DATA);
      m_byte(8'hA5, rd);
      m_bit(1'b1, ack);
      check("w_data_ack", ack, I2C_ACK);
      exp_q.push_back(8'hA5); exp_last = 8'hA5;
      check("w_rx_data", rx_data, exp_last);
      check("w_rxv_count", n_rxv - b_rxv, 1);
      m_stop();
      check("w_stop_pulse", n_stop - b_stop, 1);
      check("w_state_idle", state_slave, ST_IDLE);
      check("w_busy_end", busy, 1'b0);

      // random multi-byte write
      nb = $urandom_range(2, 4);
      b_rxv = n_rxv;
      m_start();
      m_byte(8'hA0, rd);
      m_bit(1'b1, ack);
      check("mw_addr_ack", ack, I2C_ACK);
      for (int i = 0; i < nb; i++) begin
         d = 8'($urandom);
         m_byte(d, rd);
         m_bit(1'b1, ack);
         check("mw_data_ack", ack, I2C_ACK);
         exp_q.push_back(d); exp_last = d;
         check("mw_rx_data", rx_data, exp_last);
      end
      check("mw_rxv_count", n_rxv - b_rxv, nb);
      m_stop();

      // foreign address: never ACKed, nothing received
      do a = 7'($urandom); while (a == OWN);
      b_rxv = n_rxv; b_sda = n_sda_slave;
      m_start();
      m_byte({a, 1'b0}, rd);
      m_bit(1'b1, ack);
      check("na_addr_nack", ack, I2C_NACK);
      check("na_busy", busy, 1'b0);
      check("na_state", state_slave, ST_WAIT_STOP);
      m_byte(8'($urandom), rd);
      m_bit(1'b1, ack);
      check("na_data_nack", ack, I2C_NACK);
      check("na_sda_untouched", n_sda_slave - b_sda, 0);
      check("na_no_rxv", n_rxv - b_rxv, 0);
      m_stop();
      check("na_state_idle", state_slave, ST_IDLE);
      check("na_rx_held", rx_data, exp_last);

      // read 0x3C (ACK) then 0xC3 (NACK)
      b_tx = n_txreq; b_nack = n_nack;
      tx_data = 8'h3C;
      m_start();
      m_byte(8'hA1, rd);
      m_bit(1'b1, ack);
      check("r_addr_ack", ack, I2C_ACK);
      check("r_rw", rw, 1'b1);
      check("r_txreq_first", n_txreq - b_tx, 1);
      tx_data = 8'hC3;
      m_byte(8'hFF, rd);
      check("r_byte0", rd, 8'h3C);
      m_bit(I2C_ACK, ack);
      m_byte(8'hFF, rd);
      check("r_byte1", rd, 8'hC3);
      m_bit(I2C_NACK, ack);
      check("r_txreq_count", n_txreq - b_tx, 2);
      check("r_nack_count", n_nack - b_nack, 1);
      check("r_state_wait", state_slave, ST_WAIT_STOP);
      check("r_busy_end", busy, 1'b0);
      m_stop();
      check("r_state_idle", state_slave, ST_IDLE);

      // random-length read
      nb = $urandom_range(1, 3);
      txq.delete();
      for (int i = 0; i < nb; i++) txq.push_back(8'($urandom));
      b_tx = n_txreq; b_nack = n_nack;
      tx_data = txq[0];
      m_start();
      m_byte(8'hA1, rd);
      m_bit(1'b1, ack);
      check("rr_addr_ack", ack, I2C_ACK);
      for (int i = 0; i < nb; i++) begin
         if (i + 1 < nb) tx_data = txq[i + 1];
         else tx_data = 8'($urandom);
         m_byte(8'hFF, rd);
         check("rr_byte", rd, txq[i]);
         m_bit((i + 1 < nb) ? I2C_ACK : I2C_NACK, ack);
      end
      check("rr_txreq_count", n_txreq - b_tx, nb);
      check("rr_nack_count", n_nack - b_nack, 1);
      m_stop();

      // repeated START after 4 data bits of a write, then a read
      b_rxv = n_rxv; b_tx = n_txreq;
      m_start();
      m_byte(8'hA0, rd);
      m_bit(1'b1, ack);
      check("rs_addr_ack", ack, I2C_ACK);
      for (int i = 0; i < 4; i++) m_bit(1'($urandom), ack);
      m_start();
      check("rs_state_addr", state_slave, ST_ADDR);
      check("rs_busy_drop", busy, 1'b0);
      d = 8'($urandom);
      tx_data = d;
      m_byte(8'hA1, rd);
      m_bit(1'b1, ack);
      check("rs_read_ack", ack, I2C_ACK);
      check("rs_rw", rw, 1'b1);
      check("rs_txreq", n_txreq - b_tx, 1);
      check("rs_no_rxv", n_rxv - b_rxv, 0);
      m_byte(8'hFF, rd);
      check("rs_byte", rd, d);
      m_bit(I2C_NACK, ack);
      m_stop();
      check("rs_rx_held", rx_data, exp_last);

`ifdef I2C_SLAVE_STRETCH_EN
      // byte 0x5A left unconsumed for 50 clk: SCL stretched, rx_valid held
      m_start();
      m_byte(8'hA0, rd);
      m_bit(1'b1, ack);
      rx_ready = 1'b0;
      m_byte(8'h5A, rd);
      m_bit(1'b1, ack);
      exp_q.push_back(8'h5A); exp_last = 8'h5A;
      m_scl_low = 1'b0;
      tick(5);
      check("st_scl_held", scl_w, 1'b0);
      check("st_rxv_held", rx_valid, 1'b1);
      tick(45);
      check("st_scl_held_late", scl_w, 1'b0);
      check("st_rxv_held_late", rx_valid, 1'b1);
      rx_ready = 1'b1;
      tick(1);
      check("st_scl_released", scl_w, 1'b1);
      check("st_rxv_cleared", rx_valid, 1'b0);
      tick(Q);
      m_scl_low = 1'b1;
      tick(Q);
      m_stop();
`else
      check("scl_never_driven", n_scl_slave, 0);
`endif

      // reset in the middle of a read while the slave pulls SDA low
      tx_data = 8'h00;
      m_start();
      m_byte(8'hA1, rd);
      m_bit(1'b1, ack);
      check("rr0_addr_ack", ack, I2C_ACK);
      check("rr0_sda_driven", sda_w, 1'b0);
      rst_n = 1'b0;
      #1;
      check("arst_sda_released", sda_w, 1'b1);
      check("arst_rx_data", rx_data, 8'h00);
      check("arst_flags", {rx_valid, tx_req, rw, busy, stop_det, nack_rcvd}, 6'b0);
      check("arst_state", state_slave, ST_IDLE);
      exp_last = 8'h00;
      tick(2);
      m_scl_low = 1'b0;
      tick(4);
      rst_n = 1'b1;
      tick(2 * Q);
      check("arst_idle_after", state_slave, ST_IDLE);

      // normal operation after reset
      d = 8'($urandom);
      m_start();
      m_byte(8'hA0, rd);
      m_bit(1'b1, ack);
      m_byte(d, rd);
      m_bit(1'b1, ack);
      check("post_rst_ack", ack, I2C_ACK);
      exp_q.push_back(d); exp_last = d;
      check("post_rst_rx", rx_data, exp_last);
      m_stop();

      // every accepted write byte seen once, in order
      check("rx_byte_count", rx_seen.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_seen.size(); i++) begin
         check("rx_byte_order", rx_seen[i], exp_q[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
